bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential double-dabble converter: turns the ALU's full 8-bit result into three BCD digits (hundreds, tens, units) with a start/done handshake. It sits between the ALU and the `bcd_to_7seg` decoders, replacing the 4-bit combinational converter on the Y path so results up to 255 display correctly. Conversion is iterative, one shift per clock. Outputs hold the last completed result between conversions.

## Interface
- `WIDTH`, 8: binary input width.
- `DIGITS`, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1. Elaboration fails otherwise.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a conversion of `bin_in`. Sampled only in IDLE.
- `bin_in`  in  WIDTH  unsigned binary value. Captured on the accepting edge only.
- `busy`  out  1  conversion in progress.
- `done`  out  1  single-cycle pulse; `bcd_out` updated in the same cycle.
- `bcd_out`  out  4*DIGITS  packed BCD result: [3:0] units, [7:4] tens, [11:8] hundreds (for the default configuration).

## Operation
- Reset (async assert, sync release): state IDLE, `busy`=0, `done`=0, `bcd_out`=0, internal shift/scratch registers=0, count=0.
- **IDLE**
  - On `start`=1: load shift register ← `bin_in`, clear BCD scratch, count ← 0, go to SHIFT.
  - On `start`=0: remain in IDLE.
- **SHIFT**, once per cycle:
  - For each scratch digit ≥ 5, add 3 (4-bit, no carry out).
  - Then shift {scratch, shift reg} left by 1.
  - Increment count.
- **End of SHIFT**: on the edge performing shift number WIDTH (count == WIDTH−1):
  - `bcd_out` ← post-shift scratch.
  - `done` ← 1.
  - Go to IDLE.
- `start` in SHIFT is ignored, not queued. `bin_in` changes during SHIFT have no effect.
- `done` is cleared on the next edge unless a new conversion completes on that edge, which is impossible for WIDTH ≥ 2.
- Scratch digits never exceed 9 after correction. Add-3 is applied before the shift, never after the final shift.
- Reset mid-conversion: the conversion is abandoned, `bcd_out` returns to 0, and there is no `done`.

## Timing
- Edge k samples `start`=1 in IDLE. `busy` is high from after edge k through after edge k+WIDTH−1.
- Shifts occur at edges k+1 … k+WIDTH.
- After edge k+WIDTH: `busy`=0, `done`=1, `bcd_out` valid, state IDLE.
- Latency is WIDTH edges from acceptance to `done` (8 for the default configuration).
- `start` high in the `done` cycle is accepted (state is IDLE), so back-to-back throughput is one result per WIDTH+1 cycles.
- `busy` is registered, not a decode of `start`, and is low in the accept cycle. Upstream drops `start` after one cycle or tolerates re-acceptance.

## Structure
- Package `bcd_pkg`:
  - State enum {IDLE, SHIFT}.
  - `BCD_W` = 4.
  - `ADJ_THRESH` = 5.
  - `ADJ_VAL` = 3.
  - A function computing the minimum DIGITS for a given WIDTH, used by the elaboration check.
- Sub-module `bcd_digit_adj`: combinational 4-bit "if ≥5 then +3" cell, instantiated DIGITS times via generate.
- Counter width is $clog2(WIDTH).
- `bcd_out` has its own register, separate from the scratch register.

## Test plan
- Reset, then `start` with `bin_in`=255 → after 8 edges `done`=1 for exactly one cycle, `bcd_out`=0x255, `busy` high for exactly 8 cycles.
- Values 0, 9, 10, 99, 100, 128 → `bcd_out` = 0x000, 0x009, 0x010, 0x099, 0x100, 0x128. Follow with an exhaustive sweep 0…255 against a reference model.
- `start` pulsed again 3 cycles into a conversion of 200, with `bin_in` changed to 7 → result 0x200, with no second `done`.
- `start` held continuously with `bin_in`=37 then 142 → `done` every 9 cycles, results 0x037 then 0x142, and `bcd_out` stable between `done` pulses.
- `rst_n` asserted asynchronously 4 cycles into a conversion of 255 → `busy`, `done` and `bcd_out` go to 0 immediately. After release, a fresh `start` with 63 gives 0x063 after 8 edges.
- Parameters WIDTH=4, DIGITS=2, input 15 → 0x15 after 4 edges. WIDTH=8 with DIGITS=2 → elaboration error.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, digit-cell constants and the digit-count sizing helper.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADJ_VAL    = 4'd3;

  // Number of decimal digits needed to show the largest WIDTH-bit unsigned value.
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    int d;
    max_val = (64'd1 << width) - 64'd1;
    d = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  assign adj = (digit >= ADJ_THRESH) ? digit + ADJ_VAL : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one correct-and-shift step per clock,
// start/done handshake, result held in its own register between conversions.
//
// Handshake: start is sampled only while idle; the accepting edge captures
// bin_in and raises busy. Exactly WIDTH edges later busy falls, done pulses for
// one cycle and bcd_out carries the new result. start while busy is dropped.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("bin_to_bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digit_chk
    $error("bin_to_bcd_seq: DIGITS too small to represent 2**WIDTH-1");
  end

  state_t                   state;
  logic [WIDTH-1:0]         shift_reg;
  logic [SCR_W-1:0]         scratch;
  logic [CNT_W-1:0]         count;
  logic [SCR_W-1:0]         adj;
  logic [SCR_W+WIDTH-1:0]   shifted;
  logic [SCR_W-1:0]         next_scratch;
  logic [WIDTH-1:0]         next_shift;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[i*BCD_W +: BCD_W]),
      .adj   (adj[i*BCD_W +: BCD_W])
    );
  end

  // Correction happens before the shift; the top bit of the corrected scratch
  // is always zero when DIGITS is large enough, so it falls off harmlessly.
  assign shifted      = {adj, shift_reg} << 1;
  assign next_scratch = shifted[SCR_W+WIDTH-1:WIDTH];
  assign next_shift   = shifted[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= next_scratch;
          shift_reg <= next_shift;
          count     <= count + 1'b1;
          if (count == LAST) begin
            bcd_out <= next_scratch;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed handshake/timing scenarios plus exhaustive
// and random values checked against a divide/modulo decimal reference.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  logic        start4;
  logic [3:0]  bin4;
  logic        busy4;
  logic        done4;
  logic [7:0]  bcd4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .bin_in  (bin4),
    .busy    (busy4),
    .done    (done4),
    .bcd_out (bcd4)
  );

  function automatic logic [31:0] ref_bcd(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {20'd0, h[3:0], t[3:0], u[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full conversion on the 8-bit instance with latency, busy-length,
  // result, single-cycle done and hold checks.
  task automatic conv8(input int v, input string tag);
    int edges, busy_n;
    bit got;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v[7:0];
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 8'($urandom);
    busy_n = busy ? 1 : 0;
    edges  = 0;
    got    = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    check({tag, "_latency"}, 32'(edges), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_bcd"}, {20'd0, bcd_out}, ref_bcd(v));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {20'd0, bcd_out}, ref_bcd(v));
  endtask

  task automatic conv4(input int v, input string tag);
    int edges;
    logic [31:0] exp;
    @(negedge clk);
    start4 = 1'b1;
    bin4   = v[3:0];
    @(posedge clk);
    #1;
    start4 = 1'b0;
    bin4   = 4'($urandom);
    edges  = 0;
    while (!done4 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    exp = ref_bcd(v) & 32'hff;
    check({tag, "_latency"}, 32'(edges), 32'd4);
    check({tag, "_bcd"}, {24'd0, bcd4}, exp);
  endtask

  initial begin
    int edges, gap, ndone;
    bit stable;
    logic [11:0] done_val;
    int dir_vals[6] = '{0, 9, 10, 99, 100, 128};

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    start4 = 1'b0;
    bin4   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {20'd0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv8(255, "max255");
    foreach (dir_vals[i]) conv8(dir_vals[i], $sformatf("dir%0d", dir_vals[i]));

    for (int v = 0; v < 256; v++) conv8(v, $sformatf("sweep%0d", v));
    for (int n = 0; n < 40; n++) conv8(int'($urandom_range(0, 255)), "rand");

    // start re-pulsed mid-conversion with a different bin_in must be ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd7;
    @(posedge clk);
    #1;
    start    = 1'b0;
    ndone    = 0;
    done_val = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        done_val = bcd_out;
      end
    end
    check("retrig_done_count", 32'(ndone), 32'd1);
    check("retrig_bcd", {20'd0, done_val}, 32'h200);
    check("retrig_idle", {31'd0, busy}, 32'd0);

    // start held high: back-to-back conversions every WIDTH+1 cycles
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd37;
    @(posedge clk);
    #1;
    bin_in = 8'd142;
    edges  = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("cont_latency", 32'(edges), 32'd8);
    check("cont_bcd1", {20'd0, bcd_out}, 32'h037);
    gap    = 0;
    stable = 1'b1;
    do begin
      @(posedge clk);
      #1;
      gap++;
      if (!done && bcd_out !== 12'h037) stable = 1'b0;
    end while (!done && gap < 20);
    start = 1'b0;
    check("cont_gap", 32'(gap), 32'd9);
    check("cont_stable", {31'd0, stable}, 32'd1);
    check("cont_bcd2", {20'd0, bcd_out}, 32'h142);
    @(posedge clk);
    #1;
    check("cont_stop", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_bcd", {20'd0, bcd_out}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_bcd", {20'd0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv8(63, "after_rst63");

    conv4(15, "w4_15");
    for (int v = 0; v < 16; v++) conv4(v, $sformatf("w4_sweep%0d", v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
